// File: rtl/ddr_app_bram_responder_if.sv
// App-side bus of the DDR controller user interface: command, write-data and read-data channels.
// The master is the DDR user (traffic source); the slave is the controller or its BRAM stand-in.
interface ddr_app_bram_responder_if #(
    parameter int APP_DATA_WIDTH = 64,
    parameter int APP_ADDR_WIDTH = 32,
    parameter int APP_MASK_WIDTH = 8
);
    logic [APP_ADDR_WIDTH-1:0] app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic                      app_rdy;
    logic [APP_DATA_WIDTH-1:0] app_wdf_data;
    logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic                      app_wdf_rdy;
    logic [APP_DATA_WIDTH-1:0] app_rd_data;
    logic                      app_rd_data_valid;
    logic                      app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/ddr_app_bram_responder.sv
// BRAM-backed responder for the DDR app_* interface: queued commands/write data, serial engine, read pipe.
// Define DDR_RESP_STALL_EN to gate both ready outputs with a free-running LFSR for backpressure testing.
module ddr_app_bram_responder #(
    parameter int APP_DATA_WIDTH  = 64,
    parameter int APP_ADDR_WIDTH  = 32,
    parameter int APP_MASK_WIDTH  = 8,
    parameter int DDR_ADDR_STRIDE = 8,
    parameter int MEM_DEPTH       = 256,
    parameter int RD_LATENCY      = 4,
    parameter int CMD_FIFO_DEPTH  = 4,
    parameter int WDF_DEPTH       = 4,
    parameter int CALIB_CYCLES    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   init_calib_complete,
    ddr_app_bram_responder_if.slave bus
);
    localparam int OFF_W  = $clog2(DDR_ADDR_STRIDE);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int CMD_PW = $clog2(CMD_FIFO_DEPTH);
    localparam int WDF_PW = $clog2(WDF_DEPTH);
    localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);

    localparam logic [2:0]        CMD_WRITE = 3'b000;
    localparam logic [2:0]        CMD_READ  = 3'b001;
    localparam logic [CMD_PW:0]   CMD_FULL  = (CMD_PW + 1)'(CMD_FIFO_DEPTH);
    localparam logic [WDF_PW:0]   WDF_FULL  = (WDF_PW + 1)'(WDF_DEPTH);
    localparam logic [CAL_W-1:0]  CAL_LAST  = CAL_W'(CALIB_CYCLES - 1);

    typedef enum logic {
        ENG_IDLE,
        ENG_WAIT_WDATA
    } engState_e;

    logic [CAL_W-1:0] calibCnt_q, calibCnt_d;
    logic             calib_q, calib_d;

    logic [2:0]              cmdOpArr_q  [CMD_FIFO_DEPTH];
    logic [IDX_W-1:0]        cmdIdxArr_q [CMD_FIFO_DEPTH];
    logic [CMD_PW-1:0]       cmdWrPtr_q, cmdWrPtr_d, cmdRdPtr_q, cmdRdPtr_d;
    logic [CMD_PW:0]         cmdCount_q, cmdCount_d;

    logic [APP_DATA_WIDTH-1:0] wdfDataArr_q [WDF_DEPTH];
    logic [APP_MASK_WIDTH-1:0] wdfMaskArr_q [WDF_DEPTH];
    logic [WDF_PW-1:0]         wdfWrPtr_q, wdfWrPtr_d, wdfRdPtr_q, wdfRdPtr_d;
    logic [WDF_PW:0]           wdfCount_q, wdfCount_d;

    engState_e        engState_q, engState_d;
    logic [IDX_W-1:0] pendIdx_q;

    logic [APP_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [RD_LATENCY-1:0]     pipeValid_q;
    logic [APP_DATA_WIDTH-1:0] pipeData_q [RD_LATENCY];
    logic [APP_DATA_WIDTH-1:0] rdData_q;
    logic                      rdValid_q;

    logic                      appRdy, wdfRdy;
    logic                      cmdPush, cmdPop, wdfPush, wdfPop;
    logic                      cmdValid, wdfValid;
    logic [2:0]                headOp;
    logic [IDX_W-1:0]          headIdx, memWrIdx;
    logic [APP_DATA_WIDTH-1:0] wdfHeadData, memRdWord;
    logic [APP_MASK_WIDTH-1:0] wdfHeadMask;
    logic                      memWe, rdIssue;
    logic                      unusedBits;

    // Address bits outside the word index and the per-beat end flag carry no information here.
    assign unusedBits = ^{bus.app_addr, bus.app_wdf_end};

    always_comb begin
        calibCnt_d = calibCnt_q;
        calib_d    = calib_q;
        if (!calib_q) begin
            calibCnt_d = calibCnt_q + 1'b1;
            calib_d    = (calibCnt_q == CAL_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            calibCnt_q <= '0;
            calib_q    <= 1'b0;
        end else begin
            calibCnt_q <= calibCnt_d;
            calib_q    <= calib_d;
        end
    end

`ifdef DDR_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (calib_q) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign appRdy = calib_q & (cmdCount_q < CMD_FULL) & lfsr_q[0];
    assign wdfRdy = calib_q & (wdfCount_q < WDF_FULL) & lfsr_q[1];
`else
    assign appRdy = calib_q & (cmdCount_q < CMD_FULL);
    assign wdfRdy = calib_q & (wdfCount_q < WDF_FULL);
`endif

    assign cmdPush     = bus.app_en & appRdy;
    assign wdfPush     = bus.app_wdf_wren & wdfRdy;
    assign cmdValid    = (cmdCount_q != '0);
    assign wdfValid    = (wdfCount_q != '0);
    assign headOp      = cmdOpArr_q[cmdRdPtr_q];
    assign headIdx     = cmdIdxArr_q[cmdRdPtr_q];
    assign wdfHeadData = wdfDataArr_q[wdfRdPtr_q];
    assign wdfHeadMask = wdfMaskArr_q[wdfRdPtr_q];
    assign memRdWord   = mem[headIdx];

    always_comb begin
        cmdWrPtr_d = cmdWrPtr_q + CMD_PW'(cmdPush);
        cmdRdPtr_d = cmdRdPtr_q + CMD_PW'(cmdPop);
        cmdCount_d = cmdCount_q + (CMD_PW + 1)'(cmdPush) - (CMD_PW + 1)'(cmdPop);
        wdfWrPtr_d = wdfWrPtr_q + WDF_PW'(wdfPush);
        wdfRdPtr_d = wdfRdPtr_q + WDF_PW'(wdfPop);
        wdfCount_d = wdfCount_q + (WDF_PW + 1)'(wdfPush) - (WDF_PW + 1)'(wdfPop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmdWrPtr_q <= '0;
            cmdRdPtr_q <= '0;
            cmdCount_q <= '0;
            wdfWrPtr_q <= '0;
            wdfRdPtr_q <= '0;
            wdfCount_q <= '0;
            pendIdx_q  <= '0;
        end else begin
            cmdWrPtr_q <= cmdWrPtr_d;
            cmdRdPtr_q <= cmdRdPtr_d;
            cmdCount_q <= cmdCount_d;
            wdfWrPtr_q <= wdfWrPtr_d;
            wdfRdPtr_q <= wdfRdPtr_d;
            wdfCount_q <= wdfCount_d;
            if (cmdPop) begin
                pendIdx_q <= headIdx;
            end
        end
    end

    // Queue storage needs no reset: pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (cmdPush) begin
            cmdOpArr_q[cmdWrPtr_q]  <= bus.app_cmd;
            cmdIdxArr_q[cmdWrPtr_q] <= bus.app_addr[OFF_W +: IDX_W];
        end
        if (wdfPush) begin
            wdfDataArr_q[wdfWrPtr_q] <= bus.app_wdf_data;
            wdfMaskArr_q[wdfWrPtr_q] <= bus.app_wdf_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            engState_q <= ENG_IDLE;
        end else begin
            engState_q <= engState_d;
        end
    end

    always_comb begin
        engState_d = engState_q;
        case (engState_q)
            ENG_IDLE: begin
                if (cmdValid && headOp == CMD_WRITE && !wdfValid) begin
                    engState_d = ENG_WAIT_WDATA;
                end
            end
            ENG_WAIT_WDATA: begin
                if (wdfValid) begin
                    engState_d = ENG_IDLE;
                end
            end
            default: engState_d = ENG_IDLE;
        endcase
    end

    // Unknown opcodes are popped with no strobe raised, which drops them silently.
    always_comb begin
        cmdPop   = 1'b0;
        wdfPop   = 1'b0;
        memWe    = 1'b0;
        rdIssue  = 1'b0;
        memWrIdx = headIdx;
        case (engState_q)
            ENG_IDLE: begin
                if (cmdValid) begin
                    cmdPop = 1'b1;
                    if (headOp == CMD_READ) begin
                        rdIssue = 1'b1;
                    end else if (headOp == CMD_WRITE && wdfValid) begin
                        wdfPop = 1'b1;
                        memWe  = 1'b1;
                    end
                end
            end
            ENG_WAIT_WDATA: begin
                if (wdfValid) begin
                    wdfPop   = 1'b1;
                    memWe    = 1'b1;
                    memWrIdx = pendIdx_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && memWe) begin
            for (int b = 0; b < APP_MASK_WIDTH; b++) begin
                if (!wdfHeadMask[b]) begin
                    mem[memWrIdx][b*8 +: 8] <= wdfHeadData[b*8 +: 8];
                end
            end
        end
    end

    // One array-read stage, RD_LATENCY-1 delay stages, then the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipeValid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipeData_q[i] <= '0;
            end
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            pipeValid_q[0] <= rdIssue;
            pipeData_q[0]  <= memRdWord;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeData_q[i]  <= pipeData_q[i-1];
            end
            rdValid_q <= pipeValid_q[RD_LATENCY-1];
            rdData_q  <= pipeData_q[RD_LATENCY-1];
        end
    end

    assign init_calib_complete   = calib_q;
    assign bus.app_rdy           = appRdy;
    assign bus.app_wdf_rdy       = wdfRdy;
    assign bus.app_rd_data       = rdData_q;
    assign bus.app_rd_data_valid = rdValid_q;
    assign bus.app_rd_data_end   = rdValid_q;
endmodule

// File: tb/tb_ddr_app_bram_responder.sv
// Bench for ddr_app_bram_responder: directed scenarios plus randomized traffic against a word-level model.
`timescale 1ns/1ps
module tb_ddr_app_bram_responder;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int MW = 8;
    localparam int CALIB = 16;
    localparam logic [2:0] OP_WR = 3'b000;
    localparam logic [2:0] OP_RD = 3'b001;

    logic clk = 1'b0;
    logic rst_n;
    logic initCalib;
    int   cycle = 0;
    int   checkCount = 0;
    int   passCount = 0;

    ddr_app_bram_responder_if #(.APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .APP_MASK_WIDTH(MW)) bus ();

    ddr_app_bram_responder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_calib_complete (initCalib),
        .bus                 (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Word-level reference: byte-known flags, unpaired commands/beats, expected and received reads.
    logic [63:0] refMem [256];
    logic [7:0]  refKnown [256];
    int          knownIdx [$];
    int          pendCmdIdx [$];
    logic [63:0] pendBeatData [$];
    logic [7:0]  pendBeatMask [$];
    logic [63:0] expQ [$];
    logic [63:0] rxQ [$];
    int          rxCycleQ [$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    function automatic int wordIndex(input logic [31:0] addr);
        return int'((addr / 32'd8) % 32'd256);
    endfunction

    function automatic void pairUp();
        int          idx;
        logic [63:0] d;
        logic [7:0]  m;
        while (pendCmdIdx.size() > 0 && pendBeatData.size() > 0) begin
            idx = pendCmdIdx.pop_front();
            d   = pendBeatData.pop_front();
            m   = pendBeatMask.pop_front();
            for (int b = 0; b < 8; b++) begin
                if (!m[b]) begin
                    refMem[idx][b*8 +: 8] = d[b*8 +: 8];
                    refKnown[idx][b] = 1'b1;
                end
            end
            if (refKnown[idx] == 8'hFF) knownIdx.push_back(idx);
        end
    endfunction

    always @(negedge clk) begin
        if (bus.app_rd_data_valid === 1'b1) begin
            rxQ.push_back(bus.app_rd_data);
            rxCycleQ.push_back(cycle);
            checkOutput("rdDataEnd", 64'(bus.app_rd_data_end), 64'd1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [2:0] op, input logic [31:0] addr, output int accCycle);
        int   waited;
        logic rdyNow;
        waited = 0;
        accCycle = -1;
        bus.app_cmd = op;
        bus.app_addr = addr;
        bus.app_en = 1'b1;
        forever begin
            rdyNow = bus.app_rdy;
            @(posedge clk); #1;
            if (rdyNow) begin
                accCycle = cycle;
                break;
            end
            waited++;
            if (waited > 300) begin
                checkOutput("cmdAcceptTimeout", 64'd0, 64'd1);
                break;
            end
        end
        bus.app_en = 1'b0;
        if (accCycle >= 0) begin
            if (op == OP_WR) begin
                pendCmdIdx.push_back(wordIndex(addr));
                pairUp();
            end else if (op == OP_RD) begin
                expQ.push_back(refMem[wordIndex(addr)]);
            end
        end
    endtask

    task automatic sendBeat(input logic [63:0] data, input logic [7:0] mask);
        int   waited;
        logic rdyNow;
        logic accepted;
        waited = 0;
        accepted = 1'b0;
        bus.app_wdf_data = data;
        bus.app_wdf_mask = mask;
        bus.app_wdf_wren = 1'b1;
        bus.app_wdf_end = 1'b1;
        forever begin
            rdyNow = bus.app_wdf_rdy;
            @(posedge clk); #1;
            if (rdyNow) begin
                accepted = 1'b1;
                break;
            end
            waited++;
            if (waited > 300) begin
                checkOutput("beatAcceptTimeout", 64'd0, 64'd1);
                break;
            end
        end
        bus.app_wdf_wren = 1'b0;
        bus.app_wdf_end = 1'b0;
        if (accepted) begin
            pendBeatData.push_back(data);
            pendBeatMask.push_back(mask);
            pairUp();
        end
    endtask

    task automatic waitCalib(input string tag);
        logic seenEarly;
        seenEarly = 1'b0;
        repeat (CALIB - 1) begin
            @(posedge clk); #1;
            seenEarly = seenEarly | initCalib | bus.app_rdy | bus.app_wdf_rdy;
        end
        checkOutput({tag, "EarlyReady"}, 64'(seenEarly), 64'd0);
        @(posedge clk); #1;
        checkOutput({tag, "Done"}, 64'(initCalib), 64'd1);
        checkOutput({tag, "AppRdy"}, 64'(bus.app_rdy), 64'd1);
        checkOutput({tag, "WdfRdy"}, 64'(bus.app_wdf_rdy), 64'd1);
    endtask

    task automatic waitReads();
        int guard;
        guard = 0;
        while (rxQ.size() < expQ.size() && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        idle(2);
    endtask

    task automatic compareReads(input string tag);
        checkOutput({tag, "Count"}, 64'(rxQ.size()), 64'(expQ.size()));
        while (rxQ.size() > 0 && expQ.size() > 0) begin
            checkOutput(tag, rxQ.pop_front(), expQ.pop_front());
        end
        rxQ.delete();
        expQ.delete();
        rxCycleQ.delete();
    endtask

    // Random mix of writes, beats, reads and unknown opcodes; reads only once every write has its data.
    task automatic applyStimulus(input int nOps);
        int          acc;
        int          r;
        int          idx;
        logic [31:0] addr;
        for (int n = 0; n < nOps; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3 && pendCmdIdx.size() < 3) begin
                sendCmd(OP_WR, $urandom(), acc);
            end else if (r < 6 && pendBeatData.size() < 3) begin
                sendBeat({$urandom(), $urandom()}, ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'h00);
            end else if (r < 9 && knownIdx.size() > 0) begin
                while (pendCmdIdx.size() > 0) sendBeat({$urandom(), $urandom()}, 8'h00);
                idx = knownIdx[$urandom_range(0, knownIdx.size() - 1)];
                addr = ($urandom() & 32'hFFFF_F807) | (32'(idx) << 3);
                sendCmd(OP_RD, addr, acc);
            end else if (pendCmdIdx.size() == 0) begin
                sendCmd(3'($urandom_range(2, 7)), $urandom(), acc);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        while (pendCmdIdx.size() > 0) sendBeat({$urandom(), $urandom()}, 8'h00);
        while (pendBeatData.size() > 0) sendCmd(OP_WR, $urandom(), acc);
    endtask

    initial begin
        int acc;
        int acc0;
        int waited;
        int lat;
        int rstIdx0;
        int rstIdx1;

        bus.app_en = 1'b0;
        bus.app_cmd = 3'b000;
        bus.app_addr = '0;
        bus.app_wdf_data = '0;
        bus.app_wdf_mask = '0;
        bus.app_wdf_wren = 1'b0;
        bus.app_wdf_end = 1'b0;
        for (int i = 0; i < 256; i++) begin
            refMem[i] = '0;
            refKnown[i] = 8'h00;
        end

        rst_n = 1'b0;
        idle(3);
        checkOutput("rstCalib", 64'(initCalib), 64'd0);
        checkOutput("rstAppRdy", 64'(bus.app_rdy), 64'd0);
        checkOutput("rstWdfRdy", 64'(bus.app_wdf_rdy), 64'd0);
        checkOutput("rstRdValid", 64'(bus.app_rd_data_valid), 64'd0);
        checkOutput("rstRdEnd", 64'(bus.app_rd_data_end), 64'd0);
        rst_n = 1'b1;
        waitCalib("calib");

        $display("[TB] sequential write/read of 20 words");
        for (int i = 0; i < 20; i++) begin
            sendCmd(OP_WR, 32'(i * 8), acc);
            sendBeat(64'(i), 8'h00);
        end
        idle(10);
        acc0 = -1;
        for (int i = 0; i < 20; i++) begin
            sendCmd(OP_RD, 32'(i * 8), acc);
            if (i == 0) acc0 = acc;
        end
        waitReads();
        lat = (rxCycleQ.size() > 0) ? rxCycleQ[0] - acc0 : -1;
        checkOutput("readLatency", 64'(lat), 64'd5);
        compareReads("seqRead");

        $display("[TB] byte mask");
        sendCmd(OP_WR, 32'h40, acc);
        sendBeat(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        sendCmd(OP_WR, 32'h40, acc);
        sendBeat(64'h0, 8'h0F);
        sendCmd(OP_RD, 32'h40, acc);
        waitReads();
        checkOutput("maskModel", expQ.size() > 0 ? expQ[0] : 64'h0, 64'h0000_0000_FFFF_FFFF);
        compareReads("maskRead");

        $display("[TB] beat before and after its command");
        sendBeat(64'hA5, 8'h00);
        idle(2);
        sendCmd(OP_WR, 32'h8, acc);
        sendCmd(OP_WR, 32'h10, acc);
        idle(2);
        sendBeat(64'h5A, 8'h00);
        sendCmd(OP_RD, 32'h8, acc);
        sendCmd(OP_RD, 32'h10, acc);
        waitReads();
        compareReads("orderRead");

        $display("[TB] command queue backpressure");
        for (int k = 0; k < 5; k++) sendCmd(OP_WR, 32'(32'h200 + k * 8), acc);
        checkOutput("bpRdyLow", 64'(bus.app_rdy), 64'd0);
        idle(3);
        checkOutput("bpRdyHold", 64'(bus.app_rdy), 64'd0);
        sendBeat(64'h1111_0000_0000_0001, 8'h00);
        waited = 0;
        while (bus.app_rdy !== 1'b1 && waited < 4) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("bpRdyBack", 64'(bus.app_rdy), 64'd1);
        for (int k = 1; k < 5; k++) sendBeat(64'(64'h1111_0000_0000_0000 + k + 1), 8'h00);
        for (int k = 0; k < 5; k++) sendCmd(OP_RD, 32'(32'h200 + k * 8), acc);
        waitReads();
        compareReads("bpRead");

        $display("[TB] randomized traffic");
        applyStimulus(80);
        waitReads();
        compareReads("randRead");

        $display("[TB] reset with reads in flight");
        rstIdx0 = 5;
        rstIdx1 = 65;
        sendCmd(OP_RD, 32'(rstIdx0 * 8), acc);
        sendCmd(OP_RD, 32'(rstIdx1 * 8), acc);
        rst_n = 1'b0;
        expQ.delete();
        idle(1);
        checkOutput("midRstCalib", 64'(initCalib), 64'd0);
        checkOutput("midRstAppRdy", 64'(bus.app_rdy), 64'd0);
        idle(2);
        rst_n = 1'b1;
        waitCalib("recal");
        idle(8);
        checkOutput("noValidAfterRst", 64'(rxQ.size()), 64'd0);
        rxQ.delete();
        rxCycleQ.delete();
        sendCmd(OP_RD, 32'(rstIdx0 * 8), acc);
        sendCmd(OP_RD, 32'(rstIdx1 * 8), acc);
        waitReads();
        compareReads("postRstRead");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
